// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0]  BCD_NINE   = 4'd9;
  localparam logic [31:0] SCORE_MAX  = 32'h9999_9999;
  localparam int          NUM_DIGITS = 8;

  // Out-of-range addend nibbles are treated as the largest decimal digit.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_NINE) ? BCD_NINE : d;
  endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// Single-digit BCD adder with carry in/out; one instance is reused across all digits.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] bin;

  assign bin  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign cout = (bin > 5'd9);
  // Adding 6 skips the six unused nibble codes; the carry out of bit 3 is dropped.
  assign s    = cout ? (bin[3:0] + 4'd6) : bin[3:0];

endmodule

// File: rtl/score_keeper.sv
// 8-digit BCD score accumulator with saturating serial add, high-score register and display mux.
module score_keeper
  import score_pkg::*;
#(
  parameter int          ADD_DIGITS = 2,
  parameter logic [31:0] HI_INIT    = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    play,
  input  logic                    clear,
  input  logic                    add_valid,
  input  logic [4*ADD_DIGITS-1:0] add_pts,
  output logic                    add_ready,
  input  logic                    game_over,
  input  logic                    disp_hi,
  output logic [3:0]              dig0,
  output logic [3:0]              dig1,
  output logic [3:0]              dig2,
  output logic [3:0]              dig3,
  output logic [3:0]              dig4,
  output logic [3:0]              dig5,
  output logic [3:0]              dig6,
  output logic [3:0]              dig7,
  output logic                    ovf,
  output logic                    new_hi
);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [31:0] score;
  logic [31:0] high;
  logic [31:0] work;
  logic [31:0] addend;
  logic [31:0] addend_in;
  logic [31:0] shown;
  logic [2:0]  idx;
  logic        carry;
  logic [3:0]  sum_dig;
  logic        sum_cout;

  // Addend digits beyond ADD_DIGITS are tied to zero.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_addend
    if (g < ADD_DIGITS) begin : g_live
      assign addend_in[4*g +: 4] = clamp_digit(add_pts[4*g +: 4]);
    end else begin : g_zero
      assign addend_in[4*g +: 4] = 4'd0;
    end
  end

  bcd_digit_add u_digit_add (
    .a    (work[{idx, 2'b00} +: 4]),
    .b    (addend[{idx, 2'b00} +: 4]),
    .cin  (carry),
    .s    (sum_dig),
    .cout (sum_cout)
  );

  always_comb begin
    state_nxt = state;
    add_ready = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // rst is folded in so add_ready reads 0 while reset is held.
        add_ready = play & ~clear & rst;
        if (add_valid && add_ready) begin
          accept    = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (idx == 3'd7) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= 3'd0;
      carry  <= 1'b0;
      score  <= 32'h0;
      high   <= HI_INIT;
      ovf    <= 1'b0;
      new_hi <= 1'b0;
    end else begin
      state  <= state_nxt;
      new_hi <= 1'b0;
      // Compares the committed score as it stood before this edge.
      if (game_over && (score > high)) begin
        high   <= score;
        new_hi <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= 3'd0;
            carry <= 1'b0;
          end
        end
        ADD: begin
          idx   <= idx + 3'd1;
          carry <= sum_cout;
        end
        COMMIT: begin
          if (carry) begin
            score <= SCORE_MAX;
            ovf   <= 1'b1;
          end else begin
            score <= work;
          end
        end
        default: begin
        end
      endcase
      if (clear) begin
        score <= 32'h0;
        ovf   <= 1'b0;
      end
    end
  end

  // Working copies carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      work   <= score;
      addend <= addend_in;
    end else if (state == ADD) begin
      work[{idx, 2'b00} +: 4] <= sum_dig;
    end
  end

  assign shown = disp_hi ? high : score;
  assign dig0  = shown[3:0];
  assign dig1  = shown[7:4];
  assign dig2  = shown[11:8];
  assign dig3  = shown[15:12];
  assign dig4  = shown[19:16];
  assign dig5  = shown[23:20];
  assign dig6  = shown[27:24];
  assign dig7  = shown[31:28];

endmodule

// File: tb/tb_score_keeper.sv
// Randomized self-checking bench for score_keeper against a decimal-integer reference model.
module tb_score_keeper;

  localparam logic [31:0] HI_INIT = 32'h0000_1234;
  localparam int          MAXV    = 99999999;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        play      = 1'b0;
  logic        clear     = 1'b0;
  logic        add_valid = 1'b0;
  logic [31:0] add_pts   = 32'h0;
  logic        game_over = 1'b0;
  logic        disp_hi   = 1'b0;
  logic        add_ready;
  logic [3:0]  dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
  logic        ovf;
  logic        new_hi;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int m_score  = 0;
  int m_high   = 0;
  int m_ovf    = 0;

  always #5 clk = ~clk;

  score_keeper #(.ADD_DIGITS(8), .HI_INIT(HI_INIT)) dut (
    .clk(clk), .rst(rst), .play(play), .clear(clear),
    .add_valid(add_valid), .add_pts(add_pts), .add_ready(add_ready),
    .game_over(game_over), .disp_hi(disp_hi),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
    .ovf(ovf), .new_hi(new_hi)
  );

  function automatic logic [31:0] dig_all();
    return {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
  endfunction

  function automatic int bcd2int(input logic [31:0] v);
    int r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  // Award value in decimal, with any nibble above 9 read as 9.
  function automatic int pts_int(input logic [31:0] v);
    int r = 0;
    int d;
    for (int i = 7; i >= 0; i--) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r = 32'h0;
    int t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input logic [31:0] pts);
    int s;
    s = m_score + pts_int(pts);
    if (s > MAXV) begin
      m_score = MAXV;
      m_ovf   = 1;
    end else begin
      m_score = s;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_score = 0;
    m_ovf   = 0;
  endtask

  task automatic do_add(input logic [31:0] pts, input int go_at);
    int  n;
    logic exp_hi;
    n = 0;
    exp_hi = 1'b0;
    add_valid = 1'b1;
    add_pts   = pts;
    #1;
    while (!add_ready && n < 50) begin
      tick();
      n++;
    end
    if (!add_ready) begin
      chk_cnt++;
      $display("FAIL add_accept_timeout ready=%b after %0d cycles", add_ready, n);
      add_valid = 1'b0;
      return;
    end
    tick();
    add_valid = 1'b0;
    add_pts   = 32'h0;
    for (int c = 1; c <= 9; c++) begin
      if (c == go_at) begin
        game_over = 1'b1;
        exp_hi = (m_score > m_high);
        if (exp_hi) m_high = m_score;
      end
      tick();
      game_over = 1'b0;
      if (c == go_at) begin
        chk_cnt++;
        if (new_hi !== exp_hi) $display("FAIL go_in_flight_new_hi got %b want %b", new_hi, exp_hi);
        else pass_cnt++;
      end
    end
    model_add(pts);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    play = 1'b1;
    repeat (3) tick();
    chk_cnt++;
    if (dig_all() !== 32'h0 || add_ready !== 1'b0 || ovf !== 1'b0 || new_hi !== 1'b0)
      $display("FAIL reset_hold dig=%h rdy=%b ovf=%b nh=%b want 0", dig_all(), add_ready, ovf, new_hi);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    do_add(32'h42, 0);
    chk_cnt++;
    if (dig_all() !== 32'h42) $display("FAIL pre_reset_add got %h want 00000042", dig_all());
    else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (dig_all() !== 32'h0 || add_ready !== 1'b0)
      $display("FAIL async_reset dig=%h rdy=%b want 00000000 0", dig_all(), add_ready);
    else pass_cnt++;
    m_score = 0;
    m_ovf   = 0;
    m_high  = bcd2int(HI_INIT);
    disp_hi = 1'b1;
    #1;
    rst = 1'b1;
    tick();
    chk_cnt++;
    if (dig_all() !== HI_INIT || add_ready !== 1'b1)
      $display("FAIL reset_high dig=%h rdy=%b want %h 1", dig_all(), add_ready, HI_INIT);
    else pass_cnt++;
    disp_hi = 1'b0;
  endtask

  task automatic test_carry_chain();
    do_add(32'h999, 0);
    chk_cnt++;
    if (dig_all() !== 32'h999) $display("FAIL setup_999 got %h want 00000999", dig_all());
    else pass_cnt++;
    add_valid = 1'b1;
    add_pts   = 32'h01;
    #1;
    chk_cnt++;
    if (add_ready !== 1'b1) $display("FAIL carry_ready_before got %b want 1", add_ready);
    else pass_cnt++;
    tick();
    add_valid = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      chk_cnt++;
      if (add_ready !== 1'b0) $display("FAIL busy_ready_c%0d got %b want 0", c, add_ready);
      else pass_cnt++;
      if (c == 8) begin
        chk_cnt++;
        if (dig_all() !== 32'h999) $display("FAIL partial_visible got %h want 00000999", dig_all());
        else pass_cnt++;
      end
      tick();
    end
    model_add(32'h01);
    chk_cnt++;
    if (dig_all() !== 32'h1000 || add_ready !== 1'b1 || ovf !== 1'b0)
      $display("FAIL carry_chain dig=%h rdy=%b ovf=%b want 00001000 1 0", dig_all(), add_ready, ovf);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    do_clear();
    do_add(32'h9999_9990, 0);
    do_add(32'h25, 0);
    chk_cnt++;
    if (dig_all() !== 32'h9999_9999 || ovf !== 1'b1)
      $display("FAIL saturate dig=%h ovf=%b want 99999999 1", dig_all(), ovf);
    else pass_cnt++;
    do_clear();
    chk_cnt++;
    if (dig_all() !== 32'h0 || ovf !== 1'b0)
      $display("FAIL clear_after_sat dig=%h ovf=%b want 00000000 0", dig_all(), ovf);
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    do_add(32'hFA, 0);
    chk_cnt++;
    if (dig_all() !== int2bcd(m_score)) $display("FAIL clamp got %h want %h", dig_all(), int2bcd(m_score));
    else pass_cnt++;
  endtask

  task automatic test_clear_mid_add();
    do_clear();
    do_add(32'h50, 0);
    add_valid = 1'b1;
    add_pts   = 32'h50;
    #1;
    tick();
    add_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    #1;
    chk_cnt++;
    if (add_ready !== 1'b0) $display("FAIL ready_during_clear got %b want 0", add_ready);
    else pass_cnt++;
    tick();
    clear = 1'b0;
    #1;
    m_score = 0;
    m_ovf   = 0;
    chk_cnt++;
    if (dig_all() !== 32'h0 || add_ready !== 1'b1 || ovf !== 1'b0)
      $display("FAIL clear_mid_add dig=%h rdy=%b ovf=%b want 00000000 1 0", dig_all(), add_ready, ovf);
    else pass_cnt++;
    repeat (12) tick();
    chk_cnt++;
    if (dig_all() !== 32'h0) $display("FAIL discarded_add got %h want 00000000", dig_all());
    else pass_cnt++;
  endtask

  task automatic pulse_go(input string name, input logic exp_pulse);
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    chk_cnt++;
    if (new_hi !== exp_pulse) $display("FAIL %s_new_hi got %b want %b", name, new_hi, exp_pulse);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (new_hi !== 1'b0) $display("FAIL %s_new_hi_width got %b want 0", name, new_hi);
    else pass_cnt++;
    disp_hi = 1'b1;
    #1;
    chk_cnt++;
    if (dig_all() !== int2bcd(m_high)) $display("FAIL %s_high got %h want %h", name, dig_all(), int2bcd(m_high));
    else pass_cnt++;
    disp_hi = 1'b0;
    #1;
  endtask

  task automatic test_high_score();
    do_clear();
    do_add(32'h1500, 0);
    if (m_score > m_high) m_high = m_score;
    pulse_go("go_greater", 1'b1);
    pulse_go("go_equal", 1'b0);
    do_clear();
    do_add(32'h700, 0);
    pulse_go("go_lower", 1'b0);
    do_add(32'h1000, 0);
    game_over = 1'b1;
    clear     = 1'b1;
    tick();
    game_over = 1'b0;
    clear     = 1'b0;
    if (m_score > m_high) m_high = m_score;
    m_score = 0;
    m_ovf   = 0;
    chk_cnt++;
    if (new_hi !== 1'b1 || dig_all() !== 32'h0)
      $display("FAIL go_clear nh=%b score=%h want 1 00000000", new_hi, dig_all());
    else pass_cnt++;
    disp_hi = 1'b1;
    #1;
    chk_cnt++;
    if (dig_all() !== int2bcd(m_high)) $display("FAIL go_clear_high got %h want %h", dig_all(), int2bcd(m_high));
    else pass_cnt++;
    disp_hi = 1'b0;
  endtask

  task automatic test_play();
    play      = 1'b0;
    add_valid = 1'b1;
    add_pts   = 32'h5;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk_cnt++;
      if (add_ready !== 1'b0) $display("FAIL play_low_ready got %b want 0", add_ready);
      else pass_cnt++;
      tick();
    end
    add_valid = 1'b0;
    chk_cnt++;
    if (dig_all() !== int2bcd(m_score)) $display("FAIL play_low_score got %h want %h", dig_all(), int2bcd(m_score));
    else pass_cnt++;
    play      = 1'b1;
    add_valid = 1'b1;
    add_pts   = 32'h33;
    #1;
    tick();
    add_valid = 1'b0;
    repeat (2) tick();
    play = 1'b0;
    repeat (7) tick();
    model_add(32'h33);
    chk_cnt++;
    if (dig_all() !== int2bcd(m_score) || add_ready !== 1'b0)
      $display("FAIL play_drop dig=%h rdy=%b want %h 0", dig_all(), add_ready, int2bcd(m_score));
    else pass_cnt++;
    play = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    do_clear();
    add_valid = 1'b1;
    add_pts   = 32'h11;
    #1;
    tick();
    add_pts = 32'h22;
    n = 0;
    while (!add_ready && n < 20) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (n !== 9) $display("FAIL b2b_spacing got %0d want 9", n);
    else pass_cnt++;
    tick();
    add_valid = 1'b0;
    repeat (9) tick();
    model_add(32'h11);
    model_add(32'h22);
    chk_cnt++;
    if (dig_all() !== int2bcd(m_score)) $display("FAIL b2b_score got %h want %h", dig_all(), int2bcd(m_score));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] pts;
    int          ndig;
    int          go_at;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_clear();
      end else begin
        pts  = 32'h0;
        ndig = ($urandom_range(0, 5) == 0) ? 8 : int'($urandom_range(1, 5));
        for (int d = 0; d < ndig; d++)
          pts[4*d +: 4] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        go_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : 0;
        do_add(pts, go_at);
      end
      chk_cnt++;
      if (dig_all() !== int2bcd(m_score) || ovf !== m_ovf[0])
        $display("FAIL rand_%0d dig=%h ovf=%b want %h %0d", it, dig_all(), ovf, int2bcd(m_score), m_ovf);
      else pass_cnt++;
      disp_hi = 1'b1;
      #1;
      chk_cnt++;
      if (dig_all() !== int2bcd(m_high)) $display("FAIL rand_high_%0d got %h want %h", it, dig_all(), int2bcd(m_high));
      else pass_cnt++;
      disp_hi = 1'b0;
      #1;
    end
  endtask

  initial begin
    m_high = bcd2int(HI_INIT);
    test_reset();
    test_carry_chain();
    test_saturation();
    test_clamp();
    test_clear_mid_add();
    test_high_score();
    test_play();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
